// File: rtl/pomodoro_pkg.sv
// pomodoro_pkg: shared types and BCD helpers for the Pomodoro session controller.
//   state_t   - sequencer states IDLE, LOAD, RUN, PAUSE, ALARM
//   phase_t   - session phase encoding (2'b11 is unused and treated as WORK)
//   bcd_tens  - tens digit of a 0..99 value
//   bcd_units - units digit of a 0..99 value
package pomodoro_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, ALARM} state_t;
    typedef enum logic [1:0] {WORK = 2'b00, SHORT_BREAK = 2'b01, LONG_BREAK = 2'b10} phase_t;
    function automatic logic [3:0] bcd_tens(input int unsigned x);
        return 4'(x / 10);
    endfunction
    function automatic logic [3:0] bcd_units(input int unsigned x);
        return 4'(x % 10);
    endfunction
endpackage

// File: rtl/pomodoro_sequencer_if.sv
// pomodoro_sequencer_if: user-input and countdown-datapath bundle of the session controller.
//   swPlayPause, bSkip, cnt_zero           - into the sequencer
//   load, load_min_tens/units, run, phase,
//   cycle_idx, total_done, alarm           - out of the sequencer
//   master: input/datapath side, slave: the sequencer
interface pomodoro_sequencer_if;
    logic       swPlayPause;
    logic       bSkip;
    logic       cnt_zero;
    logic       load;
    logic [3:0] load_min_tens;
    logic [3:0] load_min_units;
    logic       run;
    logic [1:0] phase;
    logic [3:0] cycle_idx;
    logic [3:0] total_done;
    logic       alarm;
    modport master (
        output swPlayPause, bSkip, cnt_zero,
        input  load, load_min_tens, load_min_units, run, phase, cycle_idx, total_done, alarm
    );
    modport slave (
        input  swPlayPause, bSkip, cnt_zero,
        output load, load_min_tens, load_min_units, run, phase, cycle_idx, total_done, alarm
    );
endinterface

// File: rtl/pomodoro_edge_detect.sv
// pomodoro_edge_detect: rise detector against a registered copy of a synchronous level.
//   timedClk - clock, rst - async active-high reset
//   din      - level input, rise - din is 1 while its previous-cycle value was 0
module pomodoro_edge_detect (
    input  logic timedClk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic prev;
    always_ff @(posedge timedClk or posedge rst)
        if (rst) prev <= 1'b0;
        else     prev <= din;
    assign rise = din & ~prev;
endmodule

// File: rtl/pomodoro_sequencer.sv
// pomodoro_sequencer: Pomodoro session controller sequencing WORK / SHORT_BREAK / LONG_BREAK.
//   timedClk - tick clock, rst - async active-high reset
//   bus      - pomodoro_sequencer_if.slave: play/pause switch, skip pulse, countdown-zero in;
//              load pulse + preset BCD digits, run enable, phase, counters, alarm out
//   Build option POMODORO_AUTO_START_EN: leaving ALARM with the switch at play starts the
//   next phase directly instead of waiting in IDLE for a fresh switch rise.
module pomodoro_sequencer
    import pomodoro_pkg::*;
#(
    parameter int unsigned WORK_MIN        = 25,
    parameter int unsigned SHORT_MIN       = 5,
    parameter int unsigned LONG_MIN        = 15,
    parameter int unsigned CYCLES_PER_LONG = 4,
    parameter int unsigned ALARM_TICKS     = 3
) (
    input logic timedClk,
    input logic rst,
    pomodoro_sequencer_if.slave bus
);
    localparam logic [3:0] W_T      = bcd_tens(WORK_MIN);
    localparam logic [3:0] W_U      = bcd_units(WORK_MIN);
    localparam logic [3:0] S_T      = bcd_tens(SHORT_MIN);
    localparam logic [3:0] S_U      = bcd_units(SHORT_MIN);
    localparam logic [3:0] L_T      = bcd_tens(LONG_MIN);
    localparam logic [3:0] L_U      = bcd_units(LONG_MIN);
    localparam logic [3:0] CYC_LAST = 4'(CYCLES_PER_LONG - 1);
    localparam logic [3:0] ALM_LAST = 4'(ALARM_TICKS - 1);

    state_t     state, nxt;
    logic [1:0] phase_q;
    logic [3:0] cycle_q, total_q, acnt;
    logic       sw_rise, is_work, alarm_end, adv_skip, adv_done;

    pomodoro_edge_detect u_edge (
        .timedClk (timedClk),
        .rst      (rst),
        .din      (bus.swPlayPause),
        .rise     (sw_rise)
    );

    // The unused 2'b11 encoding behaves as WORK everywhere.
    assign is_work   = (phase_q != SHORT_BREAK) && (phase_q != LONG_BREAK);
    assign alarm_end = (state == ALARM) && (acnt == 4'd0);
    assign adv_done  = alarm_end;
    // A switch rise in IDLE takes precedence over a simultaneous skip.
    assign adv_skip  = bus.bSkip && (((state == IDLE) && !sw_rise) ||
                                     ((state == RUN) && !bus.cnt_zero) ||
                                     (state == PAUSE));

    always_ff @(posedge timedClk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = sw_rise ? LOAD : IDLE;
            LOAD:    nxt = RUN;
            RUN:     nxt = bus.cnt_zero ? ALARM : bus.bSkip ? LOAD : !bus.swPlayPause ? PAUSE : RUN;
            PAUSE:   nxt = bus.bSkip ? IDLE : bus.swPlayPause ? RUN : PAUSE;
`ifdef POMODORO_AUTO_START_EN
            ALARM:   nxt = !alarm_end ? ALARM : bus.swPlayPause ? LOAD : IDLE;
`else
            ALARM:   nxt = alarm_end ? IDLE : ALARM;
`endif
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.load           = (state == LOAD);
        bus.run            = (state == RUN);
        bus.alarm          = (state == ALARM);
        bus.phase          = phase_q;
        bus.cycle_idx      = cycle_q;
        bus.total_done     = total_q;
        bus.load_min_tens  = (phase_q == SHORT_BREAK) ? S_T : (phase_q == LONG_BREAK) ? L_T : W_T;
        bus.load_min_units = (phase_q == SHORT_BREAK) ? S_U : (phase_q == LONG_BREAK) ? L_U : W_U;
    end

    // Alarm down-counter sits at its preset outside ALARM, so it is loaded on entry.
    always_ff @(posedge timedClk or posedge rst)
        if (rst)                 acnt <= ALM_LAST;
        else if (state == ALARM) acnt <= acnt - 4'd1;
        else                     acnt <= ALM_LAST;

    always_ff @(posedge timedClk or posedge rst)
        if (rst) begin
            phase_q <= WORK;
            cycle_q <= 4'd0;
            total_q <= 4'd0;
        end else if (adv_done) begin
            if (is_work) begin
                total_q <= (total_q == 4'd15) ? total_q : total_q + 4'd1;
                phase_q <= (cycle_q == CYC_LAST) ? LONG_BREAK : SHORT_BREAK;
                cycle_q <= (cycle_q == CYC_LAST) ? 4'd0 : cycle_q + 4'd1;
            end else begin
                phase_q <= WORK;
            end
        end else if (adv_skip) begin
            phase_q <= is_work ? SHORT_BREAK : WORK;
        end
endmodule

// File: tb/tb_pomodoro_sequencer.sv
// tb_pomodoro_sequencer: randomized scoreboard bench for pomodoro_sequencer with a session-level model.
module tb_pomodoro_sequencer;
    localparam int WORK_MIN        = 25;
    localparam int SHORT_MIN       = 5;
    localparam int LONG_MIN        = 15;
    localparam int CYCLES_PER_LONG = 4;
    localparam int ALARM_TICKS     = 3;

    typedef struct packed {
        logic       load;
        logic       run;
        logic       alarm;
        logic [1:0] phase;
        logic [3:0] cyc;
        logic [3:0] tot;
        logic [3:0] tens;
        logic [3:0] units;
    } obs_t;

    logic timedClk = 1'b0;
    logic rst = 1'b1;
    pomodoro_sequencer_if bus();

    pomodoro_sequencer #(
        .WORK_MIN        (WORK_MIN),
        .SHORT_MIN       (SHORT_MIN),
        .LONG_MIN        (LONG_MIN),
        .CYCLES_PER_LONG (CYCLES_PER_LONG),
        .ALARM_TICKS     (ALARM_TICKS)
    ) dut (
        .timedClk (timedClk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 timedClk = ~timedClk;

    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t exp_q[$];

    // Session-level model: what the user sees, not how the controller is built.
    int minutes[3] = '{WORK_MIN, SHORT_MIN, LONG_MIN};
    int  m_phase, m_since_long, m_works;
    bit  m_loading, m_counting, m_paused, m_sw_prev;
    int  m_alarm_left;

    function automatic void model_reset();
        m_phase = 0; m_since_long = 0; m_works = 0;
        m_loading = 0; m_counting = 0; m_paused = 0; m_sw_prev = 0;
        m_alarm_left = 0;
    endfunction

    function automatic void skip_phase();
        m_phase = (m_phase == 0) ? 1 : 0;
    endfunction

    function automatic void complete_phase();
        if (m_phase == 0) begin
            m_works++;
            m_since_long++;
            if (m_since_long == CYCLES_PER_LONG) begin
                m_phase = 2;
                m_since_long = 0;
            end else begin
                m_phase = 1;
            end
        end else begin
            m_phase = 0;
        end
    endfunction

    function automatic void model_step(input bit sw, input bit skip, input bit zero);
        bit rise = sw && !m_sw_prev;
        if (m_alarm_left > 0) begin
            m_alarm_left--;
            if (m_alarm_left == 0) begin
                complete_phase();
`ifdef POMODORO_AUTO_START_EN
                m_loading = sw;
`endif
            end
        end else if (m_loading) begin
            m_loading = 0;
            m_counting = 1;
        end else if (m_counting) begin
            if (zero) begin
                m_counting = 0;
                m_alarm_left = ALARM_TICKS;
            end else if (skip) begin
                skip_phase();
                m_counting = 0;
                m_loading = 1;
            end else if (!sw) begin
                m_counting = 0;
                m_paused = 1;
            end
        end else if (m_paused) begin
            if (skip) begin
                skip_phase();
                m_paused = 0;
            end else if (sw) begin
                m_paused = 0;
                m_counting = 1;
            end
        end else begin
            if (rise) m_loading = 1;
            else if (skip) skip_phase();
        end
        m_sw_prev = sw;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.load  = m_loading;
        o.run   = m_counting;
        o.alarm = (m_alarm_left > 0);
        o.phase = 2'(m_phase);
        o.cyc   = 4'(m_since_long);
        o.tot   = 4'((m_works > 15) ? 15 : m_works);
        o.tens  = 4'(minutes[m_phase] / 10);
        o.units = 4'(minutes[m_phase] % 10);
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.load  = bus.load;
        o.run   = bus.run;
        o.alarm = bus.alarm;
        o.phase = bus.phase;
        o.cyc   = bus.cycle_idx;
        o.tot   = bus.total_done;
        o.tens  = bus.load_min_tens;
        o.units = bus.load_min_units;
        return o;
    endfunction

    function automatic void check(input string name, input obs_t act, input obs_t want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got load=%0b run=%0b alarm=%0b phase=%0d cyc=%0d tot=%0d digits=%0d%0d, want load=%0b run=%0b alarm=%0b phase=%0d cyc=%0d tot=%0d digits=%0d%0d",
                     name, $time, act.load, act.run, act.alarm, act.phase, act.cyc, act.tot, act.tens, act.units,
                     want.load, want.run, want.alarm, want.phase, want.cyc, want.tot, want.tens, want.units);
        end
    endfunction

    // Inputs change 2 time units after an edge; the expectation is for the following edge.
    task automatic drive(input bit sw, input bit skip, input bit zero);
        @(posedge timedClk);
        #2;
        bus.swPlayPause = sw;
        bus.bSkip = skip;
        bus.cnt_zero = zero;
        model_step(sw, skip, zero);
        exp_q.push_back(model_obs());
    endtask

    // Asynchronous reset between edges; outputs must drop without waiting for a clock.
    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        #1;
        check("async_reset", dut_obs(), model_obs());
        #1;
        rst = 1'b0;
        model_step(bus.swPlayPause, bus.bSkip, bus.cnt_zero);
        exp_q.push_back(model_obs());
    endtask

    task automatic start_phase();
        drive(0, 0, 0);
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(1, 0, 0);
    endtask

    task automatic finish_phase();
        drive(1, 0, 1);
        repeat (ALARM_TICKS + 1) drive(1, 0, 0);
    endtask

    initial begin : monitor
        obs_t want;
        forever begin
            @(posedge timedClk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                check("cycle", dut_obs(), want);
            end
        end
    end

    initial begin : stimulus
        bit sw = 0;
        bus.swPlayPause = 0;
        bus.bSkip = 0;
        bus.cnt_zero = 0;
        #2;
        do_reset();
        start_phase();
        finish_phase();
        start_phase();
        finish_phase();
        repeat (CYCLES_PER_LONG) begin
            start_phase();
            finish_phase();
            start_phase();
            finish_phase();
        end
        start_phase();
        drive(0, 1, 1);
        repeat (ALARM_TICKS + 1) drive(0, 0, 0);
        start_phase();
        drive(1, 1, 0);
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
        drive(1, 1, 0);
        drive(1, 0, 0);
        drive(0, 1, 0);
        drive(0, 0, 0);
        start_phase();
        drive(1, 0, 1);
        drive(1, 0, 0);
        do_reset();
        drive(1, 0, 0);
        drive(1, 0, 0);
        repeat (40) begin
            start_phase();
            finish_phase();
        end
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0) sw = !sw;
            drive(sw, $urandom_range(15) == 0, $urandom_range(11) == 0);
            if ($urandom_range(599) == 0) do_reset();
        end
        drive(sw, 0, 0);
        repeat (3) @(posedge timedClk);
        #3;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pomodoro_sequencer.md
Name: pomodoro_sequencer

Overview:
Session controller for the Pomodoro BCD MM:SS countdown datapath. It sequences the phases WORK, SHORT_BREAK and LONG_BREAK, and loads the countdown with each phase's preset. It gates the countdown's run enable from the play/pause switch and raises a timed alarm at phase end. It sits between the debounced user inputs and the countdown/display path, clocked by the slow tick timedClk.

Parameters:
WORK_MIN, 25, work phase length in minutes (1..99)
SHORT_MIN, 5, short break length in minutes (1..99)
LONG_MIN, 15, long break length in minutes (1..99)
CYCLES_PER_LONG, 4, completed work phases per long break (2..15)
ALARM_TICKS, 3, timedClk cycles that alarm stays high (1..15)

Ports:
timedClk  in  1  tick clock; all state changes on its rising edge
rst  in  1  reset, asynchronous, active-high
swPlayPause  in  1  level switch; 1 = play, 0 = pause (synchronous to timedClk)
bSkip  in  1  one-cycle pulse; abandon current phase
cnt_zero  in  1  countdown datapath reads 00:00
load  out  1  one-cycle pulse; countdown loads load_min_tens/units with seconds 00
load_min_tens  out  4  BCD tens digit of current phase preset
load_min_units  out  4  BCD units digit of current phase preset
run  out  1  countdown decrement enable
phase  out  2  00 WORK, 01 SHORT_BREAK, 10 LONG_BREAK
cycle_idx  out  4  work phases completed since last long break
total_done  out  4  completed work phases, saturating at 15
alarm  out  1  phase-complete indicator

Behaviour:
- Reset (async, any state): state IDLE, phase WORK, cycle_idx 0, total_done 0, load 0, run 0, alarm 0, sw_prev 0. load_min digits = WORK_MIN digits (25 -> 2/5).
- load_min_tens/units are combinational from phase. Digits are compile-time constants: X/10 and X%10.
- sw_prev registers swPlayPause every cycle. A rise means swPlayPause=1 and sw_prev=0.
- IDLE: run=0. On a rise, go to LOAD. On bSkip, advance phase and stay in IDLE.
- LOAD: load=1 for exactly this cycle, then go to RUN. bSkip is ignored.
- RUN: run=1. Priority order:
  - cnt_zero: go to ALARM. cnt_zero wins over bSkip and pause.
  - else bSkip: advance phase and go to LOAD.
  - else swPlayPause=0: go to PAUSE.
- PAUSE: run=0. swPlayPause=1 returns to RUN with no reload. bSkip advances phase and goes to IDLE; bSkip wins over resume.
- ALARM: alarm=1 and run=0 for ALARM_TICKS cycles, counted by a 4-bit down-counter loaded on entry. On the last alarm cycle, advance phase with completion credit, then go to IDLE. bSkip and the switch are ignored during ALARM.
- Phase advance with completion (from ALARM):
  - WORK: total_done+1 (saturating at 15). If cycle_idx = CYCLES_PER_LONG-1, phase becomes LONG_BREAK and cycle_idx becomes 0. Otherwise phase becomes SHORT_BREAK and cycle_idx+1.
  - Any break: phase becomes WORK.
- Phase advance by skip: WORK becomes SHORT_BREAK, with cycle_idx and total_done unchanged. A break becomes WORK.
- Encoding 11 on phase is unreachable; if reached, it decodes as WORK.
- Latency: a switch rise in IDLE gives load in the next cycle and run one cycle after that.

Optional Feature:
POMODORO_AUTO_START_EN
- Defined: ALARM exit goes to LOAD if swPlayPause=1, so the next phase starts with no new rise. Otherwise it goes to IDLE.
- Undefined: ALARM exit always goes to IDLE; the user must toggle the switch 0->1.

Decomposition:
- Shared package pomodoro_pkg:
  - state_t {IDLE, LOAD, RUN, PAUSE, ALARM}
  - phase_t {WORK=2'b00, SHORT_BREAK=2'b01, LONG_BREAK=2'b10}
  - BCD tens/units helper functions
- One sub-module: pomodoro_edge_detect, a registered rise detector for swPlayPause, reused for buttons elsewhere.

Test Plan:
- Reset then rise on swPlayPause: load pulses exactly one cycle with digits 2/5; run=1 from the following cycle; phase=00.
- In RUN, assert cnt_zero: alarm high for exactly 3 cycles with run=0; then phase=01, cycle_idx=1, total_done=1, digits 0/5, state IDLE.
- Complete 4 work phases: after the 4th, phase=10, digits 1/5, cycle_idx=0, total_done=4.
- Same cycle in RUN with cnt_zero=1, bSkip=1, swPlayPause=0: ALARM taken; total_done increments.
- bSkip in WORK during RUN: phase=01, load pulses, total_done unchanged. Pause, then bSkip in PAUSE: phase=00, state IDLE, run=0.
- rst asserted mid-ALARM: alarm, run and load drop immediately (asynchronously); phase=00, counters 0. With POMODORO_AUTO_START_EN and the switch held at 1, an ALARM exit produces a load pulse on the next cycle.
